// File: rtl/rf_pkg.sv
// Shared register-file constants and the requester-index width helper used by
// the register-file access arbiter and its round-robin core.
package rf_pkg;
  localparam int RF_AW    = 3;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 8;

  // Width of an index over n requesters; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// NREQ-wide round-robin grant: searches upward from the slot after the last
// winner, wraps, and only moves the pointer when the caller reports a transfer.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW = clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gntIdx
);
  logic [IW-1:0] lastGnt;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt    = '0;
    gntIdx = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(lastGnt) + k) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gntIdx   = idx;
      end
    end
    // No grant may escape while the block is held in reset.
    if (!reset_n) gnt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     lastGnt <= IW'(NREQ - 1);
    else if (advance) lastGnt <= gntIdx;
  end
endmodule

// File: rtl/rf_access_arbiter.sv
// Shares one single-write/single-read register file among NREQ requesters:
// one write or read per cycle, reads answered with a one-cycle response pulse.
module rf_access_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rf_we,
  output logic [AW-1:0]      rf_wAddr,
  output logic [DW-1:0]      rf_wData,
  output logic [AW-1:0]      rf_rAddr,
  input  logic [DW-1:0]      rf_rData
);
  localparam int IW = clog2(NREQ);

  logic [IW-1:0] gntIdx;
  logic          xfer;
  logic          isWrite;
  logic          rdXfer;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selData;
  logic [AW-1:0] rAddrQ;

  rr_arbiter #(.NREQ(NREQ)) uArb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .advance (xfer),
    .gnt     (req_ready),
    .gntIdx  (gntIdx)
  );

  assign xfer    = |req_ready;
  assign isWrite = req_write[gntIdx];
  assign selAddr = req_addr[gntIdx*AW +: AW];
  assign selData = req_wdata[gntIdx*DW +: DW];
  assign rdXfer  = xfer & ~isWrite;

  assign rf_we    = xfer & isWrite;
  assign rf_wAddr = rf_we ? selAddr : '0;
  assign rf_wData = rf_we ? selData : '0;
  // Read address only moves on a read grant so the file's read mux stays quiet.
  assign rf_rAddr = rdXfer ? selAddr : rAddrQ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rAddrQ    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rAddrQ    <= rf_rAddr;
      rsp_valid <= rdXfer ? req_ready : '0;
      if (rdXfer) rsp_rdata <= rf_rData;
    end
  end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Randomized and directed bench for rf_access_arbiter with a behavioural
// round-robin/memory model checked every falling edge.
module tb_rf_access_arbiter;
  localparam int N  = 2;
  localparam int AW = 3;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     rsp_rdata, rf_wData, rf_rData;
  logic              rf_we;
  logic [AW-1:0]     rf_wAddr, rf_rAddr;

  logic [3:0]        valid4, write4, ready4, rspv4;
  logic [4*AW-1:0]   addr4;
  logic [4*DW-1:0]   wdata4;
  logic [DW-1:0]     rdata4, wD4, rD4;
  logic              we4;
  logic [AW-1:0]     wA4, rA4;

  logic [DW-1:0]     rfMem [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_access_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rf_we(rf_we),
    .rf_wAddr(rf_wAddr), .rf_wData(rf_wData), .rf_rAddr(rf_rAddr), .rf_rData(rf_rData)
  );

  rf_access_arbiter #(.NREQ(4), .AW(AW), .DW(DW)) dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(valid4), .req_write(write4),
    .req_addr(addr4), .req_wdata(wdata4), .req_ready(ready4),
    .rsp_valid(rspv4), .rsp_rdata(rdata4), .rf_we(we4),
    .rf_wAddr(wA4), .rf_wData(wD4), .rf_rAddr(rA4), .rf_rData(rD4)
  );

  // Register file behind the arbiter.
  assign rf_rData = rfMem[rf_rAddr];
  assign rD4      = rfMem[rA4];
  always @(posedge clk) if (rf_we) rfMem[rf_wAddr] <= rf_wData;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: last winner, expected memory contents, pending response.
  int          mPtr = N - 1;
  logic [DW-1:0] mMem [8];
  logic [N-1:0]  mRspV = '0;
  logic [DW-1:0] mRdata = '0;
  int          mRAddr = 0;
  bit          mRAKnown = 1'b0;

  always @(negedge clk) begin
    int g;
    int a;
    logic [N-1:0] expRdy;
    if (!reset_n) begin
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
      chk("rst_we", 64'(rf_we), 64'h0);
      mPtr = N - 1; mRspV = '0; mRdata = '0; mRAKnown = 1'b0;
    end else begin
      chk("rsp_valid", 64'(rsp_valid), 64'(mRspV));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(mRdata));
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_valid[(mPtr + k) % N]) g = (mPtr + k) % N;
      expRdy = (g < 0) ? '0 : (N'(1) << g);
      chk("req_ready", 64'(req_ready), 64'(expRdy));
      if (g >= 0 && req_write[g]) begin
        a = int'(req_addr[g*AW +: AW]);
        chk("wr_we", 64'(rf_we), 64'h1);
        chk("wr_addr", 64'(rf_wAddr), 64'(a));
        chk("wr_data", 64'(rf_wData), 64'(req_wdata[g*DW +: DW]));
        mMem[a] = req_wdata[g*DW +: DW];
        mRspV = '0;
      end else begin
        chk("idle_we", 64'(rf_we), 64'h0);
        chk("idle_waddr", 64'(rf_wAddr), 64'h0);
        chk("idle_wdata", 64'(rf_wData), 64'h0);
        if (g >= 0) begin
          a = int'(req_addr[g*AW +: AW]);
          chk("rd_raddr", 64'(rf_rAddr), 64'(a));
          mRspV = expRdy; mRdata = mMem[a]; mRAddr = a; mRAKnown = 1'b1;
        end else begin
          if (mRAKnown) chk("hold_raddr", 64'(rf_rAddr), 64'(mRAddr));
          mRspV = '0;
        end
      end
      if (g >= 0) mPtr = g;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setReq(int i, bit v, bit w, int a, logic [DW-1:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*AW +: AW]  = a[AW-1:0];
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [N-1:0] gg;
    logic [3:0]   expG;
    reset_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    valid4 = '0; write4 = '0; addr4 = '0; wdata4 = '0;
    for (int i = 0; i < 8; i++) begin
      rfMem[i] = 32'h5a5a_0000 + i;
      mMem[i]  = 32'h5a5a_0000 + i;
    end

    // Reset then idle
    #2;
    chk("t1_ready", 64'(req_ready), 64'h0);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("t1_rdata", 64'(rsp_rdata), 64'h0);
    #5 reset_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #2;
      chk("t1_idle_we", 64'(rf_we), 64'h0);
      chk("t1_idle_ready", 64'(req_ready), 64'h0);
      chk("t1_idle_rsp", 64'(rsp_valid), 64'h0);
    end

    // Single writes then a read from requester 0
    tick; setReq(0, 1, 1, 0, 32'h1111_1111);
    #1 chk("t2_wr0_ready", 64'(req_ready), 64'h1);
    chk("t2_wr0_we", 64'(rf_we), 64'h1);
    tick; setReq(0, 1, 1, 1, 32'hff00_ff00);
    #1 chk("t2_wr1_ready", 64'(req_ready), 64'h1);
    tick; setReq(0, 1, 0, 1, '0);
    #1 chk("t2_rd_ready", 64'(req_ready), 64'h1);
    chk("t2_rd_raddr", 64'(rf_rAddr), 64'h1);
    tick; setReq(0, 0, 0, 0, '0);
    #1 chk("t2_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t2_rsp_rdata", 64'(rsp_rdata), 64'hff00_ff00);
    tick; #1 chk("t2_rsp_gone", 64'(rsp_valid), 64'h0);

    // Contention from a fresh pointer
    tick; reset_n = 1'b0;
    tick; reset_n = 1'b1;
    setReq(0, 1, 1, 2, 32'h00ff_00ff);
    setReq(1, 1, 0, 0, '0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_grant", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k > 0) chk("t3_rsp", 64'(rsp_valid), (k % 2 == 0) ? 64'h2 : 64'h0);
      if (k == 2) chk("t3_rdata", 64'(rsp_rdata), 64'h1111_1111);
      tick;
    end
    #1 chk("t3_rsp_last", 64'(rsp_valid), 64'h2);
    chk("t3_rdata_last", 64'(rsp_rdata), 64'h1111_1111);

    // Read-after-write across requesters
    setReq(0, 0, 0, 0, '0);
    setReq(1, 1, 1, 3, 32'hdead_beef);
    #1 chk("t4_wr_ready", 64'(req_ready), 64'h2);
    tick; setReq(1, 0, 0, 0, '0); setReq(0, 1, 0, 3, '0);
    #1 chk("t4_rd_ready", 64'(req_ready), 64'h1);
    tick; setReq(0, 0, 0, 0, '0);
    #1 chk("t4_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t4_rsp_rdata", 64'(rsp_rdata), 64'hdead_beef);

    // Four-way fairness
    tick;
    valid4 = '1; write4 = '0;
    addr4 = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 8; k++) begin
      expG = 4'b0001 << (k % 4);
      #1 chk("t5_grant", 64'(ready4), 64'(expG));
      chk("t5_onehot", 64'($onehot(ready4)), 64'h1);
      tick;
    end
    valid4 = '0;

    // Reset while a read response is outstanding
    setReq(0, 1, 0, 2, '0);
    #1 chk("t6_rd_ready", 64'(req_ready), 64'h1);
    tick; setReq(0, 0, 0, 0, '0);
    #1 chk("t6_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t6_rsp_rdata", 64'(rsp_rdata), 64'h00ff_00ff);
    reset_n = 1'b0;
    #1 chk("t6_rsp_cleared", 64'(rsp_valid), 64'h0);
    tick;
    setReq(0, 1, 0, 4, '0); setReq(1, 1, 0, 5, '0);
    reset_n = 1'b1;
    #1 chk("t6_first_grant", 64'(req_ready), 64'h1);
    tick; setReq(0, 0, 0, 0, '0); setReq(1, 0, 0, 0, '0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); gg = req_valid & req_ready;
      @(posedge clk); #1;
      if (c % 400 == 399) begin
        req_valid = '0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] || gg[i]) begin
            if ($urandom_range(0, 99) < 70)
              setReq(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 7)), $urandom);
            else
              setReq(i, 0, 0, 0, '0);
          end else if ($urandom_range(0, 99) < 5) begin
            setReq(i, 0, 0, 0, '0);
          end
        end
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
